// File: rtl/freq_cnt_pkg.sv
// Shared state codes, range / gate-frequency constants for the frequency counter.
package freq_cnt_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RANGE_W = 3;
  localparam int unsigned STD_W   = 2;

  // bit 2 = measuring, bits [1:0] = range index; codes 3 and 7 are unused
  localparam logic [STATE_W-1:0] CLR_R0  = 3'd0;
  localparam logic [STATE_W-1:0] CLR_R1  = 3'd1;
  localparam logic [STATE_W-1:0] CLR_R2  = 3'd2;
  localparam logic [STATE_W-1:0] MEAS_R0 = 3'd4;
  localparam logic [STATE_W-1:0] MEAS_R1 = 3'd5;
  localparam logic [STATE_W-1:0] MEAS_R2 = 3'd6;

  localparam logic [RANGE_W-1:0] RANGE_R0 = 3'b001;
  localparam logic [RANGE_W-1:0] RANGE_R1 = 3'b010;
  localparam logic [RANGE_W-1:0] RANGE_R2 = 3'b100;

  localparam logic [STD_W-1:0] STD_F0 = 2'b00;
  localparam logic [STD_W-1:0] STD_F1 = 2'b01;
  localparam logic [STD_W-1:0] STD_F2 = 2'b10;

endpackage

// File: rtl/frequency_counter_ctrl.sv
// Auto-ranging controller: steps between three gate ranges on counter
// overflow / under-range flags and pulses a counter clear on each change.
module frequency_counter_ctrl
  import freq_cnt_pkg::*;
(
  input  logic               Clk,
  input  logic               Clear,
  input  logic               Cntover,
  input  logic               Cntlow,
  output logic               reset,
  output logic [RANGE_W-1:0] range,
  output logic [STD_W-1:0]   std_f_sel
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;

  // State register; Clear forces the coarse range with the counter cleared.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state <= CLR_R2;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; flags are ignored while clearing so a 2-cycle flag steps once.
  always_comb begin
    state_nxt = state;
    case (state)
      CLR_R0:  state_nxt = MEAS_R0;
      CLR_R1:  state_nxt = MEAS_R1;
      CLR_R2:  state_nxt = MEAS_R2;
      MEAS_R0: begin
        if (Cntover) state_nxt = CLR_R1;
        else         state_nxt = MEAS_R0;
      end
      MEAS_R1: begin
        if (Cntover)     state_nxt = CLR_R2;
        else if (Cntlow) state_nxt = CLR_R0;
        else             state_nxt = MEAS_R1;
      end
      MEAS_R2: begin
        if (Cntover)     state_nxt = MEAS_R2;
        else if (Cntlow) state_nxt = CLR_R1;
        else             state_nxt = MEAS_R2;
      end
      default: state_nxt = CLR_R2;
    endcase
  end

  // Moore output decode; unused codes look like CLR_R2 until they recover.
  always_comb begin
    reset     = 1'b1;
    range     = RANGE_R2;
    std_f_sel = STD_F2;
    case (state)
      CLR_R0: begin
        reset     = 1'b1;
        range     = RANGE_R0;
        std_f_sel = STD_F0;
      end
      CLR_R1: begin
        reset     = 1'b1;
        range     = RANGE_R1;
        std_f_sel = STD_F1;
      end
      CLR_R2: begin
        reset     = 1'b1;
        range     = RANGE_R2;
        std_f_sel = STD_F2;
      end
      MEAS_R0: begin
        reset     = 1'b0;
        range     = RANGE_R0;
        std_f_sel = STD_F0;
      end
      MEAS_R1: begin
        reset     = 1'b0;
        range     = RANGE_R1;
        std_f_sel = STD_F1;
      end
      MEAS_R2: begin
        reset     = 1'b0;
        range     = RANGE_R2;
        std_f_sel = STD_F2;
      end
      default: begin
        reset     = 1'b1;
        range     = RANGE_R2;
        std_f_sel = STD_F2;
      end
    endcase
  end

endmodule

// File: tb/tb_frequency_counter_ctrl.sv
// Directed bench for the auto-ranging controller with an expected-output queue.
module tb_frequency_counter_ctrl;
  import freq_cnt_pkg::*;

  logic       Clk;
  logic       Clear;
  logic       Cntover;
  logic       Cntlow;
  logic       reset;
  logic [2:0] range;
  logic [1:0] std_f_sel;

  int checks = 0;
  int errors = 0;

  // expected output word: {reset, range[2:0], std_f_sel[1:0]}
  localparam logic [5:0] E_C0 = 6'b1_001_00;
  localparam logic [5:0] E_C1 = 6'b1_010_01;
  localparam logic [5:0] E_C2 = 6'b1_100_10;
  localparam logic [5:0] E_M0 = 6'b0_001_00;
  localparam logic [5:0] E_M1 = 6'b0_010_01;
  localparam logic [5:0] E_M2 = 6'b0_100_10;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  frequency_counter_ctrl dut (
    .Clk       (Clk),
    .Clear     (Clear),
    .Cntover   (Cntover),
    .Cntlow    (Cntlow),
    .reset     (reset),
    .range     (range),
    .std_f_sel (std_f_sel)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic compare_head();
    logic [5:0] obs;
    logic [5:0] exp;
    string      tag;
    obs = {reset, range, std_f_sel};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic check_now(input logic [5:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    compare_head();
  endtask

  task automatic check_state(input logic [2:0] exp, input string tag);
    checks++;
    assert (dut.state === exp) else begin
      errors++;
      $error("FAIL %s observed state=%0d required=%0d", tag, dut.state, exp);
    end
  endtask

  // Drive flags mid-cycle, queue the expected post-edge outputs, check after the edge.
  task automatic step(input logic ov, input logic lo, input logic [5:0] exp, input string tag);
    @(negedge Clk);
    Cntover = ov;
    Cntlow  = lo;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge Clk);
    #1;
    compare_head();
  endtask

  initial begin
    Clear   = 1'b1;
    Cntover = 1'b0;
    Cntlow  = 1'b0;
    #2 Clear = 1'b0;
    #1;
    check_now(E_C2, "reset_async");
    check_state(CLR_R2, "reset_state");
    repeat (2) begin
      @(posedge Clk);
      #1;
      check_now(E_C2, "reset_held");
    end
    check_state(CLR_R2, "reset_held_state");
    @(negedge Clk);
    Clear = 1'b1;
    step(1'b0, 1'b0, E_M2, "release_meas_r2");
    check_state(MEAS_R2, "release_state");
    step(1'b0, 1'b0, E_M2, "idle_r2");

    // single-cycle Cntlow pulses walk down to R0, then saturate
    step(1'b0, 1'b1, E_C1, "low1_clr_r1");
    step(1'b0, 1'b0, E_M1, "low1_meas_r1");
    step(1'b0, 1'b1, E_C0, "low2_clr_r0");
    step(1'b0, 1'b0, E_M0, "low2_meas_r0");
    step(1'b0, 1'b1, E_M0, "low3_sat_r0");
    step(1'b0, 1'b0, E_M0, "low3_idle_r0");

    // Cntover held two cycles steps exactly once
    step(1'b1, 1'b0, E_C1, "over2_clr_r1");
    step(1'b1, 1'b0, E_M1, "over2_meas_r1");
    step(1'b0, 1'b0, E_M1, "over2_idle_r1");

    // both flags: overflow wins
    step(1'b1, 1'b1, E_C2, "both_clr_r2");
    step(1'b0, 1'b0, E_M2, "both_meas_r2");

    // over-range saturation in R2: no reset pulse
    step(1'b1, 1'b0, E_M2, "sat_over_1");
    step(1'b1, 1'b0, E_M2, "sat_over_2");
    step(1'b1, 1'b0, E_M2, "sat_over_3");
    step(1'b0, 1'b0, E_M2, "sat_over_idle");

    // Cntlow held five cycles advances ceil(5/2)=3 at most, clamped at R0
    step(1'b0, 1'b1, E_C1, "lowheld_1");
    step(1'b0, 1'b1, E_M1, "lowheld_2");
    step(1'b0, 1'b1, E_C0, "lowheld_3");
    step(1'b0, 1'b1, E_M0, "lowheld_4");
    step(1'b0, 1'b1, E_M0, "lowheld_5");
    step(1'b0, 1'b0, E_M0, "lowheld_idle");
    check_state(MEAS_R0, "meas_r0_state");

    // asynchronous Clear between edges while in MEAS_R0
    @(negedge Clk);
    #2 Clear = 1'b0;
    #1;
    check_now(E_C2, "async_clear_mid");
    check_state(CLR_R2, "async_clear_state");
    @(negedge Clk);
    Clear = 1'b1;
    step(1'b0, 1'b0, E_M2, "after_async_clear");

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
